// File: rtl/comb_dec_pkg.sv
// rtl/comb_dec_pkg.sv - shared constants for the comb decimator sequencer
// State encodings, default decimation ratio and a settle-counter width helper.
package comb_dec_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  localparam logic [1:0] RUN   = 2'd3;

  localparam int DEC_FACTOR_DEF = 8;
  localparam int PHASE_W_DEF    = $clog2(DEC_FACTOR_DEF);

  function automatic int settle_w(input int frames);
    return (frames < 2) ? 1 : $clog2(frames + 1);
  endfunction

endpackage

// File: rtl/comb_dec_sequencer_if.sv
// rtl/comb_dec_sequencer_if.sv - sample/branch/output handshake bundle for the sequencer
// COMB_DEC_OVERRUN_CNT_EN adds the overrun_cnt signal.
interface comb_dec_sequencer_if #(
  parameter int DEC_FACTOR = 8,
  parameter int PHASE_W    = 3
`ifdef COMB_DEC_OVERRUN_CNT_EN
  ,
  parameter int CNT_W      = 16
`endif
);

  logic                  en;
  logic                  in_valid;
  logic                  out_ready;
  logic [PHASE_W-1:0]    phase_sel;
  logic [DEC_FACTOR-1:0] branch_we;
  logic                  branch_clr;
  logic                  frame_done;
  logic                  out_valid;
  logic                  overrun;
  logic [1:0]            state;

`ifdef COMB_DEC_OVERRUN_CNT_EN
  logic [CNT_W-1:0]      overrun_cnt;

  modport slave (
    input  en, in_valid, out_ready,
    output phase_sel, branch_we, branch_clr, frame_done, out_valid, overrun, state,
    output overrun_cnt
  );

  modport master (
    output en, in_valid, out_ready,
    input  phase_sel, branch_we, branch_clr, frame_done, out_valid, overrun, state,
    input  overrun_cnt
  );
`else
  modport slave (
    input  en, in_valid, out_ready,
    output phase_sel, branch_we, branch_clr, frame_done, out_valid, overrun, state
  );

  modport master (
    output en, in_valid, out_ready,
    input  phase_sel, branch_we, branch_clr, frame_done, out_valid, overrun, state
  );
`endif

endinterface

// File: rtl/comb_dec_phase_cnt.sv
// rtl/comb_dec_phase_cnt.sv - modulo-DEC_FACTOR branch phase counter
// Synchronous clear wins over advance; o_wrap flags an advance out of the last phase.
module comb_dec_phase_cnt
  import comb_dec_pkg::*;
#(
  parameter int DEC_FACTOR = DEC_FACTOR_DEF,
  parameter int PHASE_W    = PHASE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_adv,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_wrap
);

  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(DEC_FACTOR - 1);

  logic [PHASE_W-1:0] r_phase;

  assign o_wrap  = i_adv && (r_phase == LAST);
  assign o_phase = r_phase;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_phase <= '0;
    end else if (i_adv) begin
      r_phase <= o_wrap ? '0 : r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/comb_dec_sequencer.sv
// rtl/comb_dec_sequencer.sv - clock-enable sequencer for the polyphase comb decimator
// COMB_DEC_OVERRUN_CNT_EN adds a saturating overrun event counter.
module comb_dec_sequencer
  import comb_dec_pkg::*;
#(
  parameter int DEC_FACTOR    = DEC_FACTOR_DEF,
  parameter int PHASE_W       = $clog2(DEC_FACTOR),
  parameter int SETTLE_FRAMES = 2
`ifdef COMB_DEC_OVERRUN_CNT_EN
  ,
  parameter int CNT_W         = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  comb_dec_sequencer_if.slave  bus
);

  localparam int                  SETTLE_W    = settle_w(SETTLE_FRAMES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_FRAMES);

  logic [1:0]          r_state;
  logic [SETTLE_W-1:0] r_settle;
  logic                r_frame_done;
  logic                r_out_valid;
  logic                r_overrun;

  logic                w_active;
  logic                w_accept;
  logic                w_phase_clr;
  logic                w_wrap;
  logic                w_ovr_evt;
  logic [PHASE_W-1:0]  w_phase;

  // Dropping en stops acceptance immediately so no half frame leaks into the bank.
  assign w_active    = (r_state == FILL) || (r_state == RUN);
  assign w_accept    = w_active && bus.en && bus.in_valid;
  assign w_phase_clr = !w_active || !bus.en;
  assign w_ovr_evt   = (r_state == RUN) && bus.en && r_frame_done && r_out_valid && !bus.out_ready;

  comb_dec_phase_cnt #(
    .DEC_FACTOR (DEC_FACTOR),
    .PHASE_W    (PHASE_W)
  ) u_phase_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_phase_clr),
    .i_adv   (w_accept),
    .o_phase (w_phase),
    .o_wrap  (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_settle     <= '0;
      r_frame_done <= 1'b0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (!bus.en) begin
      r_state      <= IDLE;
      r_frame_done <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
      case (r_state)
        IDLE: begin
          r_state <= CLEAR;
        end
        CLEAR: begin
          r_settle <= '0;
          r_state  <= FILL;
        end
        FILL: begin
          if (r_frame_done) begin
            r_settle <= r_settle + 1'b1;
            if (r_settle + 1'b1 == SETTLE_LAST) begin
              r_state <= RUN;
            end
          end
        end
        default: begin
          // A fresh frame always wins over an accept: the newest sum stays presented.
          if (r_frame_done) begin
            r_out_valid <= 1'b1;
          end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
          if (w_ovr_evt) begin
            r_overrun <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef COMB_DEC_OVERRUN_CNT_EN
  logic [CNT_W-1:0] r_overrun_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun_cnt <= '0;
    end else if (w_ovr_evt && !(&r_overrun_cnt)) begin
      r_overrun_cnt <= r_overrun_cnt + 1'b1;
    end
  end

  assign bus.overrun_cnt = r_overrun_cnt;
`endif

  assign bus.state      = r_state;
  assign bus.phase_sel  = w_phase;
  assign bus.branch_we  = w_accept ? (DEC_FACTOR'(1) << w_phase) : '0;
  assign bus.branch_clr = (r_state == CLEAR);
  assign bus.frame_done = r_frame_done;
  assign bus.out_valid  = r_out_valid;
  assign bus.overrun    = r_overrun;

endmodule

// File: doc/comb_dec_sequencer.md
Name: comb_dec_sequencer

Overview:
- Single-clock controller that sequences the 8-branch polyphase comb decimator and replaces its divided `clk_8` domain with clock enables.
- Commutates accepted input samples onto branches 0..R-1 via per-branch write enables.
- Issues a branch clear on start and suppresses output during warm-up.
- Presents a valid/ready handshake for each decimated output, with sticky overrun reporting.
- Sits between the ADC sample stream and the comb branch bank, ahead of the downstream integrator/sink.

Parameters:
- DEC_FACTOR, 8, decimation ratio R (number of polyphase branches); power of two, >=2.
- PHASE_W, 3, width of phase counter; equals log2(DEC_FACTOR).
- SETTLE_FRAMES, 2, number of complete frames discarded after start before outputs are flagged valid; >=1.
- CNT_W, 16, width of overrun counter (optional feature only).

Ports:
- clk  in  1  system clock (full input sample rate).
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low forces IDLE.
- in_valid  in  1  input sample present this cycle; stream cannot be stalled.
- phase_sel  out  PHASE_W  branch index of current accepted sample.
- branch_we  out  DEC_FACTOR  one-hot branch write enable, asserted with accepted sample.
- branch_clr  out  1  one-cycle pulse clearing all branch delay registers.
- frame_done  out  1  one-cycle pulse: full frame of R samples written.
- out_valid  out  1  decimated sum at branch-adder output is valid.
- out_ready  in  1  downstream accepts output when out_valid&out_ready.
- overrun  out  1  sticky: a frame completed while previous output unaccepted.
- state  out  2  current FSM state, for debug.

Behaviour:
- Reset (rst=1 at posedge) values:
  - state=IDLE, phase_sel=0, branch_we=0, branch_clr=0, frame_done=0, out_valid=0, overrun=0.
  - settle counter=0.
- States: IDLE=0, CLEAR=1, FILL=2, RUN=3.
- IDLE:
  - No branch_we; phase held at 0.
  - en=1 -> CLEAR.
- CLEAR (exactly 1 cycle):
  - branch_clr=1, phase=0, settle counter=0.
  - Samples arriving this cycle are ignored (no branch_we).
  - Next state FILL.
- Sample acceptance (FILL/RUN):
  - When in_valid=1, branch_we is combinationally one-hot at the current phase and phase_sel=phase in the same cycle.
  - Phase increments mod DEC_FACTOR on the next edge.
  - in_valid=0 holds phase.
- Frame completion:
  - Acceptance at phase=R-1 wraps phase to 0.
  - frame_done pulses the following cycle (1-cycle registered latency).
- FILL:
  - Each frame_done increments the settle counter.
  - On the frame_done that makes the count equal SETTLE_FRAMES -> RUN.
  - That frame does not set out_valid.
- RUN:
  - frame_done sets out_valid=1.
  - out_valid stays high until the cycle after out_valid&out_ready.
- Simultaneous accept and new frame_done: out_valid remains 1 (new data), no overrun.
- frame_done while out_valid=1 and out_ready=0:
  - overrun<=1 (sticky), out_valid remains 1.
  - The downstream holds stale sum semantics: the newest sum is presented.
- en deassert in any non-IDLE state:
  - Next state IDLE, phase=0, out_valid=0, pending frame_done suppressed.
  - overrun is retained.
  - Re-enable always passes through CLEAR and FILL again.
- overrun clears only on rst.
- rst mid-operation takes priority over all events; outputs return to reset values the following cycle.

Optional Feature:
- Macro: COMB_DEC_OVERRUN_CNT_EN.
- Defined:
  - Adds output port overrun_cnt [CNT_W-1:0], reset 0.
  - Increments on every overrun event; saturates at all-ones.
  - Cleared only by rst.
- Undefined: port and counter absent; only the sticky overrun flag exists.

Decomposition:
- Package comb_dec_pkg holds:
  - state encoding constants IDLE/CLEAR/FILL/RUN (2-bit);
  - default DEC_FACTOR=8;
  - derived PHASE_W.
- One sub-module, comb_dec_phase_cnt:
  - modulo-DEC_FACTOR counter with synchronous clear and advance enable;
  - outputs phase and wrap pulse.
- The FSM, settle counter and handshake stay in the top module.

Test Plan:
- Reset then en=1, in_valid=1 continuous:
  - branch_clr at cycle 1.
  - branch_we walks 0x01..0x80.
  - frame_done at cycles 10 and 18 with no out_valid.
  - First out_valid the cycle after the 3rd frame_done (cycle 26).
- RUN, out_ready=1 always: out_valid pulses one cycle each 8 accepted samples; overrun stays 0.
- RUN, in_valid toggling 1,0: phase advances only on valid cycles; frame_done every 16 cycles; branch_we=0 on invalid cycles.
- RUN, out_ready held 0 across two frame_done: overrun=1 at the second; with macro, overrun_cnt=1, then 2 after a third frame.
- out_ready=1 in the same cycle as a new frame_done: out_valid stays 1, overrun stays 0.
- en dropped at phase 5, re-raised 3 cycles later:
  - IDLE, then CLEAR pulse, phase restarts at 0.
  - 2 settle frames again before out_valid; prior overrun=1 retained.
